pipe_skid_reg: RTL and testbench



---
 rtl/pipe_skid_reg_pkg.sv | 22 ++
 rtl/pipe_skid_reg_sat_counter.sv | 19 +
 rtl/pipe_skid_reg.sv | 112 +++++++++++
 tb/tb_pipe_skid_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the parametrised pipeline-stage register.
// Stage wrappers size their packed payloads from the widths below.
package pipe_skid_reg_pkg;

  localparam int unsigned MEMWB_PAYLOAD_W = 150;
  localparam int unsigned STALL_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } skid_state_e;

  function automatic logic [1:0] state_occ(input skid_state_e st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the pipeline
// performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         cpu_clk_50M,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge cpu_clk_50M) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, flush, optional
// 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned        DATA_W  = MEMWB_PAYLOAD_W,
  parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}},
  parameter bit                 SKID_EN = 1'b1,
  parameter int unsigned        CNT_W   = STALL_CNT_W
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_occ(state_q);
  assign in_ready  = SKID_EN ? in_ready_q : (~out_valid | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else if (SKID_EN) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_TWO;
          end else if (out_fire) begin
            main_d  = NOP_VAL;
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = NOP_VAL;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end else begin
      // Single-register mode: a concurrent in/out fire is a straight replacement.
      if (in_fire) begin
        main_d  = in_data;
        state_d = ST_ONE;
      end else if (out_fire) begin
        main_d  = NOP_VAL;
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .cpu_clk_50M (cpu_clk_50M),
    .clr         (cpu_rst),
    .inc         (out_valid & ~out_ready),
    .count       (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: skid mode (16- and 3-bit counters) and
// single-register mode, all sharing one stimulus bus.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 150;
  localparam logic [DW-1:0] C_NOP = {6'h15, {18{8'h5A}}};

  logic          cpu_clk_50M = 1'b0;
  logic          cpu_rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [DW-1:0] od_a, od_b, od_c;
  logic [1:0]    occ_a, occ_b, occ_c;
  logic [15:0]   st_a, st_c;
  logic [2:0]    st_b;

  int tests = 0;
  int fails = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .occupancy(occ_a), .stall_cnt(st_a));

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(3)) dut_b (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .occupancy(occ_b), .stall_cnt(st_b));

  pipe_skid_reg #(.DATA_W(DW), .NOP_VAL(C_NOP), .SKID_EN(1'b0), .CNT_W(16)) dut_c (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
    .occupancy(occ_c), .stall_cnt(st_c));

  typedef struct {
    logic          rst, fl, iv, ordy;
    logic [DW-1:0] din;
    logic          e_ov, e_ir;
    logic [DW-1:0] e_od;
    logic [1:0]    e_occ;
    logic [15:0]   e_st;
  } vec_t;

  function automatic logic [DW-1:0] mk(input logic [7:0] b);
    return {6'h2A, {18{b}}};
  endfunction

  function automatic vec_t v(input logic rst, fl, iv, ordy, input logic [DW-1:0] din,
                             input logic e_ov, e_ir, input logic [DW-1:0] e_od,
                             input logic [1:0] e_occ, input logic [15:0] e_st);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.ordy = ordy; r.din = din;
    r.e_ov = e_ov; r.e_ir = e_ir; r.e_od = e_od; r.e_occ = e_occ; r.e_st = e_st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, fl, iv, ordy, input logic [DW-1:0] din);
    cpu_rst = rst; flush = fl; in_valid = iv; out_ready = ordy; in_data = din;
  endtask

  task automatic step;
    @(posedge cpu_clk_50M);
    #1;
  endtask

  vec_t tbl[22];

  initial begin
    // rst fl iv or  din         ov ir od        occ st
    tbl[0]  = v(1, 0, 0, 0, '0,       0, 1, '0,       0, 0);
    tbl[1]  = v(1, 0, 1, 1, mk(8'h99),0, 1, '0,       0, 0);
    tbl[2]  = v(0, 0, 1, 1, mk(8'hA5),1, 1, mk(8'hA5),1, 0);
    tbl[3]  = v(0, 0, 1, 1, mk(8'hA6),1, 1, mk(8'hA6),1, 0);
    tbl[4]  = v(0, 0, 1, 1, mk(8'hA7),1, 1, mk(8'hA7),1, 0);
    tbl[5]  = v(0, 0, 0, 1, mk(8'hEE),0, 1, '0,       0, 0);
    tbl[6]  = v(0, 0, 1, 0, mk(8'hD1),1, 1, mk(8'hD1),1, 0);
    tbl[7]  = v(0, 0, 1, 0, mk(8'hD2),1, 0, mk(8'hD1),2, 1);
    tbl[8]  = v(0, 0, 1, 0, mk(8'hD3),1, 0, mk(8'hD1),2, 2);
    tbl[9]  = v(0, 0, 1, 1, mk(8'hD3),1, 1, mk(8'hD2),1, 2);
    tbl[10] = v(0, 0, 1, 1, mk(8'hD3),1, 1, mk(8'hD3),1, 2);
    tbl[11] = v(0, 0, 0, 1, mk(8'hEE),0, 1, '0,       0, 2);
    tbl[12] = v(0, 0, 1, 0, mk(8'hD5),1, 1, mk(8'hD5),1, 2);
    tbl[13] = v(0, 0, 1, 0, mk(8'hD6),1, 0, mk(8'hD5),2, 3);
    tbl[14] = v(0, 1, 1, 0, mk(8'hD4),0, 1, '0,       0, 4);
    tbl[15] = v(0, 0, 0, 1, mk(8'hD4),0, 1, '0,       0, 4);
    tbl[16] = v(0, 0, 1, 0, mk(8'hD7),1, 1, mk(8'hD7),1, 4);
    tbl[17] = v(0, 0, 0, 0, mk(8'hEE),1, 1, mk(8'hD7),1, 5);
    tbl[18] = v(0, 0, 0, 0, mk(8'hEE),1, 1, mk(8'hD7),1, 6);
    tbl[19] = v(0, 0, 0, 0, mk(8'hEE),1, 1, mk(8'hD7),1, 7);
    tbl[20] = v(1, 1, 1, 0, mk(8'hD8),0, 1, '0,       0, 0);
    tbl[21] = v(0, 0, 0, 1, mk(8'hD8),0, 1, '0,       0, 0);

    #1;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].din);
      step();
      chk($sformatf("row%0d.out_valid", i), DW'(ov_a),  DW'(tbl[i].e_ov));
      chk($sformatf("row%0d.in_ready", i),  DW'(ir_a),  DW'(tbl[i].e_ir));
      chk($sformatf("row%0d.out_data", i),  od_a,       tbl[i].e_od);
      chk($sformatf("row%0d.occupancy", i), DW'(occ_a), DW'(tbl[i].e_occ));
      chk($sformatf("row%0d.stall_cnt", i), DW'(st_a),  DW'(tbl[i].e_st));
    end

    // Saturation: 3-bit counter stops at 7, 16-bit one keeps counting.
    drive(0, 0, 1, 0, mk(8'hB0));
    step();
    chk("sat.b_out_data", od_b, mk(8'hB0));
    chk("sat.b_start", DW'(st_b), DW'(0));
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, '0);
      step();
      chk($sformatf("sat.b_cnt_k%0d", k), DW'(st_b), DW'((k > 7) ? 7 : k));
    end
    chk("sat.a_cnt_10", DW'(st_a), DW'(10));

    // Single-register mode.
    drive(1, 0, 0, 0, '0);
    step();
    drive(0, 0, 0, 0, '0);
    #1;
    chk("c.rst_out_valid", DW'(ov_c), DW'(0));
    chk("c.rst_out_data", od_c, C_NOP);
    chk("c.rst_occ", DW'(occ_c), DW'(0));
    chk("c.rst_in_ready", DW'(ir_c), DW'(1));
    drive(0, 0, 1, 0, mk(8'hE1));
    step();
    chk("c.push_out_valid", DW'(ov_c), DW'(1));
    chk("c.push_out_data", od_c, mk(8'hE1));
    chk("c.push_occ", DW'(occ_c), DW'(1));
    drive(0, 0, 1, 0, mk(8'hE2));
    #1;
    chk("c.stalled_in_ready", DW'(ir_c), DW'(0));
    step();
    chk("c.hold_out_data", od_c, mk(8'hE1));
    chk("c.hold_occ", DW'(occ_c), DW'(1));
    drive(0, 0, 1, 1, mk(8'hE3));
    #1;
    chk("c.comb_in_ready", DW'(ir_c), DW'(1));
    step();
    chk("c.replace_out_data", od_c, mk(8'hE3));
    chk("c.replace_occ", DW'(occ_c), DW'(1));
    chk("c.replace_out_valid", DW'(ov_c), DW'(1));
    drive(0, 0, 1, 1, mk(8'hE4));
    step();
    chk("c.replace2_out_data", od_c, mk(8'hE4));
    chk("c.replace2_occ", DW'(occ_c), DW'(1));
    drive(0, 0, 0, 1, '0);
    step();
    chk("c.drain_out_valid", DW'(ov_c), DW'(0));
    chk("c.drain_out_data", od_c, C_NOP);
    chk("c.drain_occ", DW'(occ_c), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Single-register mode must never report more than one entry.
  always @(negedge cpu_clk_50M) begin
    if (!cpu_rst && occ_c !== 2'bxx && occ_c > 2'd1) begin
      tests++;
      fails++;
      $display("FAIL c.occ_le_1: got %0d expected <=1", occ_c);
    end
  end

endmodule
